// File: rtl/roulette_pkg.sv
// Shared types and helpers for the roulette spin driver and its LED decoder.
package roulette_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        LANDED = 2'd2
    } spin_state_t;

    function automatic int n_groups(input int n_leds, input int group_size);
        return (n_leds + group_size - 1) / group_size;
    endfunction

endpackage

// File: rtl/spin_led_decoder.sv
// Combinational ring-position to per-group mux-select encoder.
// Select 0 darkens a group; select k lights LED k-1 of that group.
module spin_led_decoder
    import roulette_pkg::*;
#(
    parameter int N_LEDS     = 38,
    parameter int GROUP_SIZE = 7
) (
    input  logic [$clog2(N_LEDS)-1:0]                                     pos,
    output logic [n_groups(N_LEDS, GROUP_SIZE)*$clog2(GROUP_SIZE+1)-1:0] mux_sel
);

    localparam int N_GROUPS = n_groups(N_LEDS, GROUP_SIZE);
    localparam int SEL_W    = $clog2(GROUP_SIZE + 1);

    // Out-of-range positions fall through and leave every group dark.
    always_comb begin
        mux_sel = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if ((int'(pos) < N_LEDS) && ((int'(pos) / GROUP_SIZE) == g)) begin
                mux_sel[g*SEL_W +: SEL_W] = SEL_W'((int'(pos) % GROUP_SIZE) + 1);
            end
        end
    end

endmodule

// File: rtl/roulette_spin_driver.sv
// Roulette LED ring driver: spins LAPS laps, decelerates and lands on a target LED.
// Optional macro SPIN_BLINK_EN makes the winning LED blink while landed.
module roulette_spin_driver
    import roulette_pkg::*;
#(
    parameter int N_LEDS      = 38,
    parameter int GROUP_SIZE  = 7,
    parameter int BASE_PERIOD = 2_500_000,
    parameter int LAPS        = 3,
    parameter int DECEL_STEPS = 8,
    parameter int DECEL_INC   = 1_000_000
) (
    input  logic                                                          clk,
    input  logic                                                          reset,
    input  logic                                                          start,
    input  logic [$clog2(N_LEDS)-1:0]                                     target,
    input  logic                                                          abort,
    output logic                                                          busy,
    output logic                                                          done,
    output logic                                                          err,
    output logic [$clog2(N_LEDS)-1:0]                                     pos,
    output logic [n_groups(N_LEDS, GROUP_SIZE)*$clog2(GROUP_SIZE+1)-1:0] mux_sel
);

    localparam int N_GROUPS   = n_groups(N_LEDS, GROUP_SIZE);
    localparam int SEL_W      = $clog2(GROUP_SIZE + 1);
    localparam int MUX_W      = N_GROUPS * SEL_W;
    localparam int POS_W      = $clog2(N_LEDS);
    localparam int POS_XW     = POS_W + 1;
    localparam int STEPS_MAX  = LAPS * N_LEDS + N_LEDS - 1;
    localparam int STEPS_W    = $clog2(STEPS_MAX + 1);
    localparam int MAX_PERIOD = BASE_PERIOD + DECEL_INC * DECEL_STEPS;
    localparam int TICK_W     = $clog2(MAX_PERIOD + 1);

    localparam logic [POS_XW-1:0] N_LEDS_X = POS_XW'(N_LEDS);

    spin_state_t        state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [MUX_W-1:0]   mux_sel_q, mux_sel_d;

    logic [MUX_W-1:0]   dec_sel;
    logic               led_lit;
    logic               target_ok;
    logic [POS_XW-1:0]  offset_raw;
    logic [POS_XW-1:0]  offset;
    logic [STEPS_W-1:0] load_steps;
    logic [STEPS_W-1:0] decel_idx;
    logic [TICK_W-1:0]  period_m1;
    logic [POS_W-1:0]   pos_next;

    // Forward distance to the target plus the fixed laps; the final steps
    // stretch linearly so the wheel visibly slows before it lands.
    always_comb begin
        target_ok  = {1'b0, target} < N_LEDS_X;
        offset_raw = {1'b0, target} + N_LEDS_X - {1'b0, pos_q};
        offset     = (offset_raw >= N_LEDS_X) ? (offset_raw - N_LEDS_X) : offset_raw;
        load_steps = STEPS_W'(LAPS * N_LEDS) + STEPS_W'(offset);
        decel_idx  = STEPS_W'(DECEL_STEPS) - steps_left_q + STEPS_W'(1);
        period_m1  = TICK_W'(BASE_PERIOD - 1);
        if (steps_left_q <= STEPS_W'(DECEL_STEPS)) begin
            period_m1 = TICK_W'(BASE_PERIOD - 1) + TICK_W'(DECEL_INC) * TICK_W'(decel_idx);
        end
        pos_next = (pos_q == POS_W'(N_LEDS - 1)) ? '0 : (pos_q + POS_W'(1));
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        tick_d       = tick_q;
        steps_left_d = steps_left_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, LANDED: begin
                    if (start) begin
                        if (target_ok) begin
                            steps_left_d = load_steps;
                            tick_d       = '0;
                            state_d      = SPIN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SPIN: begin
                    if (tick_q == period_m1) begin
                        tick_d       = '0;
                        pos_d        = pos_next;
                        steps_left_d = steps_left_q - STEPS_W'(1);
                        if (steps_left_q == STEPS_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = LANDED;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SPIN_BLINK_EN
    localparam int BLINK_PERIOD = 8 * BASE_PERIOD;
    localparam int BLINK_W      = $clog2(BLINK_PERIOD);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    // Each fresh landing restarts the blink in the "on" phase.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if ((state_q == LANDED) && (state_d == LANDED)) begin
            if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_on_d  = blink_on_q;
            end
        end
        led_lit = blink_on_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    assign led_lit = 1'b1;
`endif

    // Decoding the next position keeps mux_sel aligned with pos on the same cycle.
    spin_led_decoder #(
        .N_LEDS     (N_LEDS),
        .GROUP_SIZE (GROUP_SIZE)
    ) u_decoder (
        .pos     (pos_d),
        .mux_sel (dec_sel)
    );

    always_comb begin
        mux_sel_d = dec_sel;
        if ((state_d == IDLE) || !led_lit) begin
            mux_sel_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            tick_q       <= '0;
            steps_left_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mux_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            tick_q       <= tick_d;
            steps_left_q <= steps_left_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mux_sel_q    <= mux_sel_d;
        end
    end

    assign busy    = (state_q == SPIN);
    assign done    = done_q;
    assign err     = err_q;
    assign pos     = pos_q;
    assign mux_sel = mux_sel_q;

endmodule

// File: tb/tb_roulette_spin_driver.sv
// Self-checking bench for roulette_spin_driver with a small ring (10 LEDs, groups of 4).
module tb_roulette_spin_driver;

    localparam int N     = 10;
    localparam int GS    = 4;
    localparam int P     = 2;
    localparam int LAPS  = 1;
    localparam int DECEL = 3;
    localparam int INC   = 1;

    typedef struct {
        int         cycles;
        int         steps;
        int         last_period;
        logic [3:0] pos;
        logic [8:0] mux;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] target;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pos;
    logic [8:0] mux_sel;

    int   vectors = 0;
    int   miscompares = 0;
    int   model_pos = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    roulette_spin_driver #(
        .N_LEDS      (N),
        .GROUP_SIZE  (GS),
        .BASE_PERIOD (P),
        .LAPS        (LAPS),
        .DECEL_STEPS (DECEL),
        .DECEL_INC   (INC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .target  (target),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .pos     (pos),
        .mux_sel (mux_sel)
    );

    function automatic logic [8:0] enc(input int p);
        logic [8:0] m;
        m = 9'((p % GS) + 1);
        return m << (3 * (p / GS));
    endfunction

    function automatic exp_t model_spin(input int cur, input int tgt);
        exp_t e;
        int   per;
        e.steps       = LAPS * N + ((tgt - cur + N) % N);
        e.cycles      = 0;
        e.last_period = 0;
        for (int s = e.steps; s >= 1; s--) begin
            per = (s > DECEL) ? P : (P + INC * (DECEL - s + 1));
            e.cycles += per;
            if (s == 1) e.last_period = per;
        end
        e.pos = 4'(tgt);
        e.mux = enc(tgt);
        return e;
    endfunction

    // Starts a spin at a falling edge and returns once done is seen (or the budget runs out).
    task automatic do_spin(input logic [3:0] tgt, output int cycles, output logic busy_seen,
                           output int steps, output int first_adv, output int last_period,
                           output logic saw_wrap, output logic timed_out);
        logic [3:0] prev;
        int         last_chg;
        start  = 1'b1;
        target = tgt;
        @(negedge clk);
        busy_seen   = busy;
        start       = 1'b0;
        prev        = pos;
        cycles      = 0;
        steps       = 0;
        first_adv   = -1;
        last_period = 0;
        last_chg    = 0;
        saw_wrap    = 1'b0;
        timed_out   = 1'b1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (pos !== prev) begin
                steps++;
                if (first_adv < 0) first_adv = n;
                if (prev == 4'd9 && pos == 4'd0) saw_wrap = 1'b1;
                last_period = n - last_chg;
                last_chg    = n;
                prev        = pos;
            end
            if (done === 1'b1) begin
                cycles    = n;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        target = 4'd0;
        repeat (3) @(negedge clk);
        vectors++; if (pos !== 4'd0)     begin miscompares++; $display("[TB] FAIL reset.pos: got %0d, expected 0", pos); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset.busy: got %b, expected 0", busy); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset.done: got %b, expected 0", done); end
        vectors++; if (err !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset.err: got %b, expected 0", err); end
        vectors++; if (mux_sel !== 9'd0) begin miscompares++; $display("[TB] FAIL reset.mux_sel: got %h, expected 0", mux_sel); end
        reset     = 1'b0;
        model_pos = 0;
        @(negedge clk);
    endtask

    task automatic test_basic_spin();
        exp_t e;
        int   cyc, steps, first_adv, last_per;
        logic busy_seen, wrap, to;
        exp_q.push_back(model_spin(model_pos, 3));
        do_spin(4'd3, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (to !== 1'b0)        begin miscompares++; $display("[TB] FAIL basic.timeout: done not seen within budget"); end
        vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL basic.busy: got %b, expected 1", busy_seen); end
        vectors++; if (first_adv != P)     begin miscompares++; $display("[TB] FAIL basic.first_adv: got %0d, expected %0d", first_adv, P); end
        vectors++; if (cyc != e.cycles)    begin miscompares++; $display("[TB] FAIL basic.cycles: got %0d, expected %0d", cyc, e.cycles); end
        vectors++; if (steps != e.steps)   begin miscompares++; $display("[TB] FAIL basic.steps: got %0d, expected %0d", steps, e.steps); end
        vectors++; if (pos !== e.pos)      begin miscompares++; $display("[TB] FAIL basic.pos: got %0d, expected %0d", pos, e.pos); end
        vectors++; if (mux_sel !== e.mux)  begin miscompares++; $display("[TB] FAIL basic.mux_sel: got %h, expected %h", mux_sel, e.mux); end
        model_pos = 3;
        @(negedge clk);
        vectors++; if (done !== 1'b0)      begin miscompares++; $display("[TB] FAIL basic.done_pulse: got %b, expected 0", done); end
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("[TB] FAIL basic.busy_landed: got %b, expected 0", busy); end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   cyc, steps, first_adv, last_per;
        logic busy_seen, wrap, to;
        exp_q.push_back(model_spin(model_pos, 8));
        do_spin(4'd8, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (cyc != e.cycles || to) begin miscompares++; $display("[TB] FAIL wrap.pre_cycles: got %0d, expected %0d", cyc, e.cycles); end
        vectors++; if (pos !== e.pos)      begin miscompares++; $display("[TB] FAIL wrap.pre_pos: got %0d, expected %0d", pos, e.pos); end
        model_pos = 8;
        exp_q.push_back(model_spin(model_pos, 1));
        do_spin(4'd1, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (to !== 1'b0)        begin miscompares++; $display("[TB] FAIL wrap.timeout: done not seen within budget"); end
        vectors++; if (wrap !== 1'b1)      begin miscompares++; $display("[TB] FAIL wrap.9_to_0: got %b, expected 1", wrap); end
        vectors++; if (steps != e.steps)   begin miscompares++; $display("[TB] FAIL wrap.steps: got %0d, expected %0d", steps, e.steps); end
        vectors++; if (last_per != e.last_period) begin miscompares++; $display("[TB] FAIL wrap.landing_period: got %0d, expected %0d", last_per, e.last_period); end
        vectors++; if (cyc != e.cycles)    begin miscompares++; $display("[TB] FAIL wrap.cycles: got %0d, expected %0d", cyc, e.cycles); end
        vectors++; if (pos !== e.pos)      begin miscompares++; $display("[TB] FAIL wrap.pos: got %0d, expected %0d", pos, e.pos); end
        vectors++; if (mux_sel !== e.mux)  begin miscompares++; $display("[TB] FAIL wrap.mux_sel: got %h, expected %h", mux_sel, e.mux); end
        model_pos = 1;
    endtask

    task automatic test_same_target();
        exp_t e;
        int   cyc, steps, first_adv, last_per;
        logic busy_seen, wrap, to;
        exp_q.push_back(model_spin(model_pos, 8));
        do_spin(4'd8, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (pos !== e.pos || to) begin miscompares++; $display("[TB] FAIL same.pre_pos: got %0d, expected %0d", pos, e.pos); end
        model_pos = 8;
        exp_q.push_back(model_spin(model_pos, 8));
        do_spin(4'd8, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (to !== 1'b0)        begin miscompares++; $display("[TB] FAIL same.timeout: done not seen within budget"); end
        vectors++; if (steps != e.steps)   begin miscompares++; $display("[TB] FAIL same.steps: got %0d, expected %0d", steps, e.steps); end
        vectors++; if (cyc != e.cycles)    begin miscompares++; $display("[TB] FAIL same.cycles: got %0d, expected %0d", cyc, e.cycles); end
        vectors++; if (pos !== e.pos)      begin miscompares++; $display("[TB] FAIL same.pos: got %0d, expected %0d", pos, e.pos); end
        vectors++; if (mux_sel !== e.mux)  begin miscompares++; $display("[TB] FAIL same.mux_sel: got %h, expected %h", mux_sel, e.mux); end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   n;
        logic got_done;
        exp_q.push_back(model_spin(model_pos, 5));
        start  = 1'b1;
        target = 4'd5;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        repeat (3) begin @(negedge clk); n++; end
        start  = 1'b1;
        target = 4'd2;
        @(negedge clk);
        n++;
        start = 1'b0;
        vectors++; if (err !== 1'b0)  begin miscompares++; $display("[TB] FAIL ignored.err: got %b, expected 0", err); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ignored.busy: got %b, expected 1", busy); end
        got_done = 1'b0;
        while (n < 500 && !got_done) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got_done = 1'b1;
        end
        e = exp_q.pop_front();
        vectors++; if (got_done !== 1'b1) begin miscompares++; $display("[TB] FAIL ignored.timeout: done not seen within budget"); end
        vectors++; if (n != e.cycles)     begin miscompares++; $display("[TB] FAIL ignored.cycles: got %0d, expected %0d", n, e.cycles); end
        vectors++; if (pos !== e.pos)     begin miscompares++; $display("[TB] FAIL ignored.pos: got %0d, expected %0d", pos, e.pos); end
        model_pos = 5;
    endtask

    task automatic test_abort();
        logic [3:0] held;
        start  = 1'b1;
        target = 4'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        held  = pos;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort.busy: got %b, expected 0", busy); end
        vectors++; if (mux_sel !== 9'd0) begin miscompares++; $display("[TB] FAIL abort.mux_sel: got %h, expected 0", mux_sel); end
        vectors++; if (pos !== held)     begin miscompares++; $display("[TB] FAIL abort.pos: got %0d, expected %0d", pos, held); end
        repeat (4) @(negedge clk);
        vectors++; if (pos !== held || mux_sel !== 9'd0) begin miscompares++; $display("[TB] FAIL abort.hold: got pos %0d mux %h, expected pos %0d mux 0", pos, mux_sel, held); end
        start  = 1'b1;
        abort  = 1'b1;
        target = 4'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort.over_start: got busy %b, expected 0", busy); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort.still_idle: got busy %b, expected 0", busy); end
        model_pos = int'(held);
    endtask

    task automatic test_err();
        int pulses;
        start  = 1'b1;
        target = 4'd12;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (err !== 1'b1)     begin miscompares++; $display("[TB] FAIL err.pulse: got %b, expected 1", err); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL err.busy: got %b, expected 0", busy); end
        vectors++; if (mux_sel !== 9'd0) begin miscompares++; $display("[TB] FAIL err.mux_sel: got %h, expected 0", mux_sel); end
        vectors++; if (pos !== 4'(model_pos)) begin miscompares++; $display("[TB] FAIL err.pos: got %0d, expected %0d", pos, model_pos); end
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (err === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0)      begin miscompares++; $display("[TB] FAIL err.single: got %0d extra pulses, expected 0", pulses); end
    endtask

    task automatic test_reset_mid_spin();
        start  = 1'b1;
        target = 4'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        vectors++; if (busy !== 1'b1)    begin miscompares++; $display("[TB] FAIL rstmid.busy_before: got %b, expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (pos !== 4'd0)     begin miscompares++; $display("[TB] FAIL rstmid.pos: got %0d, expected 0", pos); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid.flags: got busy %b done %b err %b, expected 000", busy, done, err); end
        vectors++; if (mux_sel !== 9'd0) begin miscompares++; $display("[TB] FAIL rstmid.mux_sel: got %h, expected 0", mux_sel); end
        model_pos = 0;
    endtask

    task automatic test_blink();
        exp_t       e;
        int         cyc, steps, first_adv, last_per, bad;
        logic       busy_seen, wrap, to;
        logic [8:0] want;
        exp_q.push_back(model_spin(model_pos, 6));
        do_spin(4'd6, cyc, busy_seen, steps, first_adv, last_per, wrap, to);
        e = exp_q.pop_front();
        vectors++; if (pos !== e.pos || to) begin miscompares++; $display("[TB] FAIL blink.pos: got %0d, expected %0d", pos, e.pos); end
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge clk);
`ifdef SPIN_BLINK_EN
            want = (((i / 16) % 2) == 0) ? e.mux : 9'd0;
`else
            want = e.mux;
`endif
            if (mux_sel !== want) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL blink.pattern: got %0d wrong samples, expected 0", bad); end
        model_pos = 6;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_spin();
        test_wrap();
        test_same_target();
        test_start_ignored();
        test_abort();
        test_err();
        test_reset_mid_spin();
        test_blink();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
